// File: rtl/down_counter_pkg.sv
// down_counter_pkg: state encoding and key indices shared by the down-counter timer.
package down_counter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam int KEY_LOAD = 1;
    localparam int KEY_START = 2;
    localparam int KEY_STEP = 3;
endpackage

// File: rtl/down_counter_timer_key_press_detect.sv
// key_press_detect: 2-flop synchronizer, optional debounce filter, one-cycle falling-edge press pulse.
// Debounce filter is built only when DOWN_COUNTER_TIMER_DEBOUNCE_EN is defined.
module key_press_detect #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_press
);
    logic [1:0] r_sync;
    logic [1:0] r_fill;
    logic       r_prev;
    logic       r_armed;
    logic       w_level;
    // A key held low through reset release stays disarmed until a real released level is seen.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_fill  <= 2'b00;
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key};
            r_fill  <= {r_fill[0], 1'b1};
            r_prev  <= w_level;
            r_armed <= r_armed | (r_fill[1] & r_sync[1]);
        end
    end
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif
    assign o_press = r_armed & r_prev & ~w_level;
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: 4-bit loadable down-counter with start/pause, single step and done flag.
// Define DOWN_COUNTER_TIMER_DEBOUNCE_EN to debounce KEY[3:1].
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [3:0] SW,
    output logic [3:0] LEDG,
    output logic [1:0] LEDR
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [3:1]    w_press;
    logic          w_load, w_start, w_step, w_wrap;
    logic [3:0]    w_dec;
    state_t        r_state;
    logic [3:0]    r_count;
    logic [PW-1:0] r_presc;
    for (genvar i = 1; i < 4; i++) begin : g_key
        key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .i_clk   (CLOCK_50),
            .i_rst_n (KEY[0]),
            .i_key   (KEY[i]),
            .o_press (w_press[i])
        );
    end
    assign w_load  = w_press[KEY_LOAD];
    assign w_start = w_press[KEY_START];
    assign w_step  = w_press[KEY_STEP];
    assign w_wrap  = r_presc == PW'(TICK_DIV - 1);
    assign w_dec   = r_count - 4'd1;
    // Pause leaves the prescaler untouched so a resume finishes the partial tick.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_presc <= '0;
        end else if (w_load) begin
            r_count <= SW;
            r_presc <= '0;
            r_state <= (SW == 4'd0) ? DONE : IDLE;
        end else begin
            case (r_state)
                IDLE, PAUSE: begin
                    if (w_start && (r_state == PAUSE || r_count != 4'd0)) begin
                        r_state <= RUN;
                    end else if (w_step && r_count != 4'd0) begin
                        r_count <= w_dec;
                        if (w_dec == 4'd0) r_state <= DONE;
                    end
                end
                RUN: begin
                    if (w_start) begin
                        r_state <= PAUSE;
                    end else if (w_wrap) begin
                        r_presc <= '0;
                        r_count <= w_dec;
                        if (w_dec == 4'd0) r_state <= DONE;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign LEDG = r_count;
    assign LEDR = {r_state == DONE, r_state == RUN};
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed and random key sequences on two timers (TICK_DIV 4 and 8),
// compared every cycle against a reference built from the key-press and counting rules.
module tb_down_counter_timer;
    localparam int DEB = 16;
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
    localparam int PH  = DEB + 4;
    localparam int GAP = DEB + 4;
`else
    localparam int LAT = 3;
    localparam int PH  = 1;
    localparam int GAP = 4;
`endif
    localparam int TD [2] = '{4, 8};
    logic       clk = 1'b0;
    logic [3:0] key;
    logic [3:0] sw;
    logic [3:0] ledg4, ledg8;
    logic [1:0] ledr4, ledr8;
    int checks = 0;
    int errors = 0;
    int m_cnt [2] = '{0, 0};
    int m_ph [2] = '{0, 0};
    bit m_run [2] = '{0, 0};
    bit m_done [2] = '{0, 0};
    logic [3:1] s1 = '1, s2 = '1, armed = '0, pl = '1;
    bit v1 = 0, v2 = 0;
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
    logic [3:1] filt = '1;
    int rl [1:3] = '{0, 0, 0};
`endif

    always #5 clk = ~clk;

    down_counter_timer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(DEB)) dut4 (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDG(ledg4), .LEDR(ledr4));
    down_counter_timer #(.TICK_DIV(8), .DEBOUNCE_CYCLES(DEB)) dut8 (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDG(ledg8), .LEDR(ledr8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a press acts two edges after the first low post-reset sample that follows a high one.
    task automatic model_step();
        logic [3:1] y, lev, p;
        if (!key[0]) begin
            for (int d = 0; d < 2; d++) begin
                m_cnt[d] = 0; m_ph[d] = 0; m_run[d] = 0; m_done[d] = 0;
            end
            v1 = 0; v2 = 0; armed = '0; pl = '1;
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
            filt = '1;
            for (int k = 1; k < 4; k++) rl[k] = 0;
`endif
        end else begin
            y = v2 ? s2 : 3'b111;
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
            lev = filt;
`else
            lev = y;
`endif
            p = armed & pl & ~lev;
            armed = armed | (v2 ? s2 : 3'b000);
            pl = lev;
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
            for (int k = 1; k < 4; k++) begin
                if (y[k] != filt[k]) begin
                    rl[k]++;
                    if (rl[k] == DEB) begin
                        filt[k] = y[k];
                        rl[k] = 0;
                    end
                end else rl[k] = 0;
            end
`endif
            s2 = s1; v2 = v1; s1 = key[3:1]; v1 = 1;
            for (int d = 0; d < 2; d++) begin
                if (p[1]) begin
                    m_cnt[d] = int'(sw); m_ph[d] = 0; m_run[d] = 0; m_done[d] = (sw == 0);
                end else if (m_done[d]) begin
                end else if (m_run[d]) begin
                    if (p[2]) m_run[d] = 0;
                    else begin
                        m_ph[d]++;
                        if (m_ph[d] == TD[d]) begin
                            m_ph[d] = 0;
                            m_cnt[d]--;
                            if (m_cnt[d] == 0) begin
                                m_done[d] = 1; m_run[d] = 0;
                            end
                        end
                    end
                end else if (p[2] && m_cnt[d] != 0) begin
                    m_run[d] = 1;
                end else if (p[3] && m_cnt[d] != 0) begin
                    m_cnt[d]--;
                    m_done[d] = (m_cnt[d] == 0);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ledg4", {28'd0, ledg4}, m_cnt[0]);
        chk("ledr4", {30'd0, ledr4}, {m_done[0], m_run[0]});
        chk("ledg8", {28'd0, ledg8}, m_cnt[1]);
        chk("ledr8", {30'd0, ledr8}, {m_done[1], m_run[1]});
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        key = key & ~m;
        repeat (hold) cyc();
        key = key | m;
        repeat (GAP) cyc();
    endtask

    initial begin
        int n, v, w, op;
        int tch [3];
        logic [3:0] last;
        key = 4'b1110;
        sw = 4'd0;
        repeat (3) cyc();
        chk("rst_ledg", {28'd0, ledg4}, 0);
        chk("rst_ledr", {30'd0, ledr4}, 0);
        key[0] = 1'b1;
        repeat (4) cyc();
        sw = 4'd5;
        press(4'b0010, PH);
        chk("load5_ledg", {28'd0, ledg4}, 5);
        chk("load5_ledr", {30'd0, ledr4}, 0);
        sw = 4'd3;
        press(4'b0010, PH);
        key[2] = 1'b0;
        n = 0;
        last = ledg4;
        for (int i = 0; i < LAT + 16; i++) begin
            cyc();
            if (i == PH - 1) key[2] = 1'b1;
            if (i == LAT - 1) chk("run_ledr", {30'd0, ledr4}, 2'b01);
            if (ledg4 != last) begin
                if (n < 3) tch[n] = i;
                n++;
                last = ledg4;
            end
        end
        chk("tick_count", n, 3);
        chk("tick1_at", tch[0], LAT + 3);
        chk("tick2_at", tch[1], LAT + 7);
        chk("tick3_at", tch[2], LAT + 11);
        chk("done_ledr", {30'd0, ledr4}, 2'b10);
        repeat (30) cyc();
        chk("done_hold", {28'd0, ledg4}, 0);
`ifndef DOWN_COUNTER_TIMER_DEBOUNCE_EN
        sw = 4'd6;
        press(4'b0010, PH);
        press(4'b0100, PH);
        w = 0;
        while (!(m_run[1] && m_ph[1] == 3) && w < 50) begin
            cyc();
            w++;
        end
        chk("pause_align_bound", w < 50, 1);
        key[2] = 1'b0; cyc(); key[2] = 1'b1; cyc(); cyc();
        chk("paused_ledr", {30'd0, ledr8}, 0);
        v = int'(ledg8);
        repeat (100) cyc();
        chk("pause_hold", {28'd0, ledg8}, v);
        key[2] = 1'b0; cyc(); key[2] = 1'b1; cyc(); cyc();
        chk("resume_ledr", {30'd0, ledr8}, 2'b01);
        cyc(); cyc();
        chk("resume_partial", {28'd0, ledg8}, v);
        cyc();
        chk("resume_dec", {28'd0, ledg8}, v - 1);
`endif
        sw = 4'd2;
        press(4'b0010, PH);
        press(4'b1000, PH);
        chk("step1", {28'd0, ledg4}, 1);
        press(4'b1000, PH);
        chk("step2", {28'd0, ledg4}, 0);
        chk("step2_done", {30'd0, ledr4}, 2'b10);
        press(4'b1000, PH);
        chk("step3_floor", {28'd0, ledg4}, 0);
        sw = 4'd4;
        press(4'b0110, PH);
        chk("load_wins_ledg", {28'd0, ledg4}, 4);
        chk("load_wins_ledr", {30'd0, ledr4}, 0);
        sw = 4'd0;
        press(4'b0010, PH);
        chk("load0_done", {30'd0, ledr4}, 2'b10);
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                key[0] = 1'b0;
                repeat ($urandom_range(1, 3)) cyc();
                key[0] = 1'b1;
                repeat (GAP) cyc();
            end
            op = $urandom_range(0, 5);
            case (op)
                0: begin sw = 4'($urandom_range(0, 15)); press(4'b0010, PH + $urandom_range(0, 2)); end
                1: press(4'b0100, PH + $urandom_range(0, 2));
                2: press(4'b1000, PH + $urandom_range(0, 2));
                3: begin sw = 4'($urandom_range(1, 15)); press(4'b0110, PH + $urandom_range(0, 2)); end
                4: press(4'b1100, PH + $urandom_range(0, 2));
                default: repeat ($urandom_range(1, 30)) cyc();
            endcase
        end
        sw = 4'd9;
        press(4'b0010, PH);
        press(4'b0100, PH);
        repeat (3) cyc();
        key[0] = 1'b0;
        cyc();
        chk("midrun_rst_ledg", {28'd0, ledg4}, 0);
        chk("midrun_rst_ledr", {30'd0, ledr4}, 0);
        chk("midrun_rst_ledg8", {28'd0, ledg8}, 0);
        sw = 4'd7;
        key[2:1] = 2'b00;
        repeat (2) cyc();
        key[0] = 1'b1;
        repeat (PH + 10) cyc();
        key[2:1] = 2'b11;
        repeat (GAP) cyc();
        chk("held_through_rst_ledg", {28'd0, ledg4}, 0);
        chk("held_through_rst_ledr", {30'd0, ledr4}, 0);
`ifdef DOWN_COUNTER_TIMER_DEBOUNCE_EN
        sw = 4'd5;
        press(4'b0010, PH);
        key[3] = 1'b0;
        repeat (10) cyc();
        key[3] = 1'b1;
        repeat (40) cyc();
        chk("glitch_ignored", {28'd0, ledg4}, 5);
        press(4'b1000, PH);
        chk("debounced_step", {28'd0, ledg4}, 4);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
